// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests,
// buffers returned words with their PC and hands {instr, pc} to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [CW:0] LIMIT = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;

    logic [31:0]   pcq [FIFO_DEPTH];
    logic [PW-1:0] pcq_wr;
    logic [PW-1:0] pcq_rd;
    logic [CW-1:0] outstanding;

    logic [31:0]   buf_instr [FIFO_DEPTH];
    logic [31:0]   buf_pc    [FIFO_DEPTH];
    logic [PW-1:0] buf_wr;
    logic [PW-1:0] buf_rd;
    logic [CW-1:0] buf_count;

    logic [CW-1:0] drop_cnt;

    logic [CW:0]   used;
    logic          has_credit;
    logic          req_fire;
    logic          rsp_take;
    logic          rsp_drop;
    logic          buf_push;
    logic          buf_pop;

    // Credit counts words in flight plus words buffered; a pop this
    // cycle does not free a slot until the next cycle.
    assign used       = {1'b0, outstanding} + {1'b0, buf_count};
    assign has_credit = used < LIMIT;

    assign imem_req_valid = !rst && !redirect_valid && has_credit;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is spurious and ignored.
    assign rsp_take = imem_rsp_valid && (outstanding != '0);
    assign rsp_drop = drop_cnt != '0;
    assign buf_push = rsp_take && !rsp_drop && !redirect_valid;

    assign out_valid = !rst && (buf_count != '0);
    assign buf_pop   = out_valid && out_ready && !redirect_valid;
    assign out_instr = out_valid ? buf_instr[buf_rd] : NOP;
    assign out_pc    = out_valid ? buf_pc[buf_rd] : 32'h0;

    // Fetch PC: restart on redirect, otherwise advance on each accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'h3;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // In-flight PC queue pointers and outstanding-request count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            outstanding <= '0;
        end else begin
            if (req_fire) begin
                pcq_wr <= pcq_wr + 1'b1;
            end
            if (rsp_take) begin
                pcq_rd <= pcq_rd + 1'b1;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
        end
    end

    // In-flight PC storage: remember the address of every accepted request.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq[pcq_wr] <= fetch_pc;
        end
    end

    // Stale-response counter: everything still in flight at a redirect is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= outstanding - CW'(rsp_take);
        end else if (rsp_take && rsp_drop) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // Instruction buffer control: flush on redirect, else push/pop.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
        end else begin
            if (buf_push) begin
                buf_wr <= buf_wr + 1'b1;
            end
            if (buf_pop) begin
                buf_rd <= buf_rd + 1'b1;
            end
            buf_count <= buf_count + CW'(buf_push) - CW'(buf_pop);
        end
    end

    // Instruction buffer storage: pair each returned word with its request PC.
    always_ff @(posedge clk) begin
        if (buf_push) begin
            buf_instr[buf_wr] <= imem_rsp_data;
            buf_pc[buf_wr]    <= pcq[pcq_rd];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table, hand-written
// redirect/reset sequences and a randomized phase against a scoreboard.
module tb_fetch_unit;

    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    typedef struct {
        logic        r;
        logic        rr;
        logic        orr;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_opc;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int          epoch = 0;
    logic [31:0] exp_fetch = 32'h0;
    mreq_t       memq[$];
    sb_t         sb[$];
    logic [31:0] fired[$];

    logic        st_req_valid;
    logic        st_req_fire;
    logic [31:0] st_addr;
    logic        st_out_valid;
    logic        st_out_fire;
    logic [31:0] st_out_pc;
    logic [31:0] st_out_instr;

    vec_t tv[18];

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, play memory, check at negedge, update models.
    task automatic step(input logic r, input logic rr, input logic orr,
                        input logic rv, input logic [31:0] rp);
        int    out_m;
        int    fifo_m;
        mreq_t m;
        sb_t   e;
        rst            = r;
        imem_req_ready = rr;
        out_ready      = orr;
        redirect_valid = rv;
        redirect_pc    = rp;
        if (r) begin
            memq.delete();
            sb.delete();
        end
        out_m          = memq.size();
        fifo_m         = sb.size();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (memq.size() > 0 && memq[0].due == cyc) begin
            m = memq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m.addr ^ KEY;
            if (m.epoch == epoch && !rv) begin
                sb.push_back('{m.addr, m.addr ^ KEY});
            end
        end
        @(negedge clk);
        st_req_valid = imem_req_valid;
        st_addr      = imem_req_addr;
        st_req_fire  = imem_req_valid && rr;
        st_out_valid = out_valid;
        st_out_pc    = out_pc;
        st_out_instr = out_instr;
        st_out_fire  = out_valid && orr && !rv;
        check1("req_valid", imem_req_valid,
               !r && !rv && (out_m + fifo_m < DEPTH));
        if (imem_req_valid) begin
            check32("req_addr", imem_req_addr, exp_fetch);
        end
        check1("out_valid", out_valid, !r && (fifo_m != 0));
        if (!out_valid) begin
            check32("empty_instr", out_instr, NOP);
            check32("empty_pc", out_pc, 32'h0);
        end
        if (st_out_fire) begin
            fired.push_back(out_pc);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty cyc=%0d got pc=%h want no output",
                         cyc, out_pc);
            end else begin
                e = sb.pop_front();
                check32("out_pc", out_pc, e.pc);
                check32("out_instr", out_instr, e.instr);
            end
        end
        if (st_req_fire) begin
            memq.push_back('{cyc + lat, imem_req_addr, epoch});
        end
        if (r) begin
            exp_fetch = 32'h0;
            epoch++;
        end else if (rv) begin
            exp_fetch = rp & ~32'h3;
            epoch++;
            sb.delete();
        end else if (st_req_fire) begin
            exp_fetch = exp_fetch + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tv[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        tv[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        tv[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
        tv[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        tv[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
        tv[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tv[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tv[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tv[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        tv[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};

        @(posedge clk);
        #1;

        // Reset, first fetch, back-pressure stall/release, reset mid-run.
        lat = 1;
        for (int i = 0; i < 18; i++) begin
            step(tv[i].r, tv[i].rr, tv[i].orr, 1'b0, 32'h0);
            check1("tv_req_valid", st_req_valid, tv[i].e_rv);
            if (tv[i].e_rv) begin
                check32("tv_req_addr", st_addr, tv[i].e_addr);
            end
            check1("tv_out_valid", st_out_valid, tv[i].e_ov);
            check32("tv_out_pc", st_out_pc, tv[i].e_opc);
            check32("tv_out_instr", st_out_instr,
                    tv[i].e_ov ? (tv[i].e_opc ^ KEY) : NOP);
        end

        // Streaming with 1-cycle memory: strictly sequential PCs.
        lat = 1;
        do_reset();
        fired.delete();
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (i == 2) begin
                check1("stream_first_valid", st_out_valid, 1'b1);
            end
        end
        if (fired.size() < 10) begin
            total++;
            bad++;
            $display("FAIL stream_count got=%0d want>=10", fired.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                check32("stream_pc", fired[i], 32'(i * 4));
            end
        end

        // 2-cycle memory, two stale requests in flight at the redirect.
        lat = 2;
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        fired.delete();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        check1("redir_rsp_seen", imem_rsp_valid, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        end
        if (fired.size() < 2) begin
            total++;
            bad++;
            $display("FAIL redir2_timeout got=%0d outputs want>=2", fired.size());
        end else begin
            check32("redir2_first", fired[0], 32'h0000_0100);
            check32("redir2_second", fired[1], 32'h0000_0104);
        end

        // Misaligned redirect coincident with a response and a pop, then stalled memory.
        lat = 1;
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        fired.delete();
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
        check1("redir5_pop_attempt", st_out_valid, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check1("redir5_req_fire", st_req_fire, 1'b1);
        check32("redir5_addr", st_addr, 32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            check1("hold_valid", st_req_valid, 1'b1);
            check32("hold_addr", st_addr, 32'h0000_0204);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        end
        if (fired.size() < 2) begin
            total++;
            bad++;
            $display("FAIL redir5_timeout got=%0d outputs want>=2", fired.size());
        end else begin
            check32("redir5_first", fired[0], 32'h0000_0200);
            check32("redir5_second", fired[1], 32'h0000_0204);
        end

        // Randomized traffic for both memory latencies.
        for (int l = 1; l <= 2; l++) begin
            lat = l;
            do_reset();
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(0, 99) == 0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 19) == 0,
                     $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
